k_vector_loader: RTL

Parametrised SHA-256 round-constant loader. On `start` it autonomously walks a constant memory, issuing one pipelined read per cycle over a configurable-latency read port. It packs each returned word into a flat constant vector and flags completion, with stall support and a per-word stream output. It sits between the K-constant ROM and the compression core, replacing the per-address, externally sequenced vector builder.

---
 rtl/k_vector_loader_if.sv | 23 ++
 rtl/k_vector_loader.sv | 131 +++++++++++++
 2 files changed

// File: rtl/k_vector_loader_if.sv
// Read port between the K-constant loader (master) and the constant ROM (slave).
interface k_vector_loader_if #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 64
);
    localparam int AW = $clog2(DEPTH);

    logic                  mem_rd;
    logic [AW-1:0]         mem_addr;
    logic [WORD_WIDTH-1:0] mem_data;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_data
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_data
    );
endinterface

// File: rtl/k_vector_loader.sv
// SHA-256 round-constant loader: walks the K ROM with pipelined reads
// and packs every returned word into a flat constant vector.
module k_vector_loader #(
    parameter int WORD_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int MEM_LATENCY = 1
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic                        i_hold,
    k_vector_loader_if.master           mem,
    output logic [DEPTH*WORD_WIDTH-1:0] o_k_vector,
    output logic [WORD_WIDTH-1:0]       o_cur_k_value,
    output logic                        o_cur_k_valid,
    output logic                        o_busy,
    output logic                        o_k_vector_complete
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [CW-1:0]               r_issue;
    logic [CW-1:0]               r_cap;
    logic                        r_mem_rd;
    logic [AW-1:0]               r_mem_addr;
    logic                        r_pv [MEM_LATENCY];
    logic [AW-1:0]               r_pi [MEM_LATENCY];
    logic [DEPTH*WORD_WIDTH-1:0] r_k_vec;
    logic [WORD_WIDTH-1:0]       r_cur;
    logic                        r_cur_valid;
    logic                        w_load;
    logic                        w_issue;
    logic                        w_cap;
    logic [AW-1:0]               w_cap_idx;

    assign w_cap     = r_pv[MEM_LATENCY-1];
    assign w_cap_idx = r_pi[MEM_LATENCY-1];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // r_issue counts reads already placed on the port, so DEPTH means
    // the final read is being presented this cycle.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_load       = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (r_issue == CW'(DEPTH)) begin
                    w_state_next = S_DRAIN;
                end else if (!i_hold) begin
                    w_issue = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_cap && r_cap == CW'(DEPTH - 1)) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_issue     <= '0;
            r_cap       <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_k_vec     <= '0;
            r_cur       <= '0;
            r_cur_valid <= 1'b0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pi[i] <= '0;
            end
        end else begin
            r_mem_rd <= w_load | w_issue;
            if (w_load) begin
                r_mem_addr <= '0;
                r_issue    <= CW'(1);
                r_cap      <= '0;
                r_k_vec    <= '0;
            end else if (w_issue) begin
                r_mem_addr <= r_issue[AW-1:0];
                r_issue    <= r_issue + CW'(1);
            end
            r_pv[0] <= r_mem_rd;
            r_pi[0] <= r_mem_addr;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pi[i] <= r_pi[i-1];
            end
            r_cur_valid <= w_cap;
            if (w_cap) begin
                r_k_vec[int'(w_cap_idx)*WORD_WIDTH +: WORD_WIDTH] <= mem.mem_data;
                r_cur <= mem.mem_data;
                r_cap <= r_cap + CW'(1);
            end
        end
    end

    assign mem.mem_rd          = r_mem_rd;
    assign mem.mem_addr        = r_mem_addr;
    assign o_k_vector          = r_k_vec;
    assign o_cur_k_value       = r_cur;
    assign o_cur_k_valid       = r_cur_valid;
    assign o_busy              = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign o_k_vector_complete = (r_state == S_DONE);
endmodule
